delay_timer_monitor: RTL and testbench



---
 rtl/delay_timer_pkg.sv | 9 +
 rtl/delay_timer_monitor_edge_sync.sv | 29 ++
 rtl/delay_timer_monitor.sv | 120 ++++++++++++
 tb/tb_delay_timer_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: types shared by the delay timer and its measurement monitor
package delay_timer_pkg;
    typedef enum logic [1:0] {ONE_SHOT = 2'b00, DLY_OPERATE = 2'b01, DLY_RELEASE = 2'b10, DLY_DUAL = 2'b11} mode_e;
    typedef enum logic [1:0] {OK = 2'b00, ABORT = 2'b01, OVERFLOW = 2'b10} status_e;
    typedef enum logic [1:0] {IDLE, WAIT_ASSERT, ASSERTED, WAIT_RELEASE} state_e;
    function automatic mode_e classify(input logic a, input logic r);
        return (a | r) ? mode_e'({r, a}) : DLY_OPERATE;
    endfunction
endpackage

// File: rtl/delay_timer_monitor_edge_sync.sv
// edge_sync: 2-flop synchronizer followed by registered rise/fall detection
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q, sync_d;
    logic rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync_d = {sync_q[1:0], pin};
        rise_d = sync_q[1] & ~sync_q[2];
        fall_d = ~sync_q[1] & sync_q[2];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/delay_timer_monitor.sv
// delay_timer_monitor: recovers mode and latencies of each trigger cycle from the timer pins
module delay_timer_monitor
    import delay_timer_pkg::*;
#(
    parameter int WEIGHT_BIT_WIDTH = 8,
    parameter int IMM_TOL = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger_in,
    input  logic                        delay_out_n,
    output logic                        result_valid,
    output logic [1:0]                  result_mode,
    output logic [1:0]                  result_status,
    output logic [WEIGHT_BIT_WIDTH-1:0] result_assert,
    output logic [WEIGHT_BIT_WIDTH-1:0] result_release,
    output logic [WEIGHT_BIT_WIDTH-1:0] result_width
);
    localparam int W = WEIGHT_BIT_WIDTH;
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] TOL = W'(IMM_TOL);
    logic trig_rise, trig_fall, out_rise, out_fall;
    edge_sync u_trig (.clk(clk), .rst(rst), .pin(trigger_in), .rise(trig_rise), .fall(trig_fall));
    edge_sync u_out (.clk(clk), .rst(rst), .pin(delay_out_n), .rise(out_rise), .fall(out_fall));
    state_e state_q, state_d;
    status_e status, status_q, status_d;
    mode_e mode_q, mode_d;
    logic [W-1:0] asrt_q, asrt_d, asrt_i, rel_q, rel_d, rel_i, wid_q, wid_d, wid_i;
    logic [W-1:0] res_asrt_q, res_asrt_d, res_rel_q, res_rel_d, res_wid_q, res_wid_d;
    logic valid_q, valid_d, emit, one_shot, ovf;
    always_comb begin
        asrt_i = asrt_q + W'(state_q == WAIT_ASSERT);
        wid_i = wid_q + W'(state_q == ASSERTED || state_q == WAIT_RELEASE);
        rel_i = rel_q + W'(state_q == WAIT_RELEASE);
        ovf = (asrt_i == MAX) | (wid_i == MAX) | (rel_i == MAX);
        state_d = state_q;
        asrt_d = asrt_i;
        wid_d = wid_i;
        rel_d = rel_i;
        emit = 1'b0;
        one_shot = 1'b0;
        status = OK;
        case (state_q)
            IDLE: begin
                asrt_d = '0;
                wid_d = '0;
                rel_d = '0;
                if (trig_rise) state_d = out_fall ? ASSERTED : WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (out_fall) state_d = trig_fall ? WAIT_RELEASE : ASSERTED;
                else if (trig_fall) begin
                    emit = 1'b1;
                    status = ABORT;
                end
            end
            ASSERTED: begin
                if (trig_fall) begin
                    state_d = WAIT_RELEASE;
                    emit = out_rise;
                end else if (out_rise) begin
                    emit = 1'b1;
                    one_shot = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                emit = out_rise | trig_rise;
                status = out_rise ? OK : ABORT;
            end
        endcase
        if (ovf && !emit) begin
            emit = 1'b1;
            status = OVERFLOW;
        end
        // a retrigger restarts measurement in the same cycle its abort record is emitted
        if (emit) begin
            state_d = (state_q == WAIT_RELEASE && trig_rise) ? WAIT_ASSERT : IDLE;
            asrt_d = '0;
            wid_d = '0;
            rel_d = '0;
        end
        valid_d = emit;
        mode_d = emit ? (one_shot ? ONE_SHOT : classify(asrt_i > TOL, rel_i > TOL)) : mode_q;
        status_d = emit ? status : status_q;
        res_asrt_d = emit ? asrt_i : res_asrt_q;
        res_rel_d = emit ? rel_i : res_rel_q;
        res_wid_d = emit ? wid_i : res_wid_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            asrt_q <= '0;
            wid_q <= '0;
            rel_q <= '0;
            valid_q <= 1'b0;
            mode_q <= ONE_SHOT;
            status_q <= OK;
            res_asrt_q <= '0;
            res_rel_q <= '0;
            res_wid_q <= '0;
        end else begin
            state_q <= state_d;
            asrt_q <= asrt_d;
            wid_q <= wid_d;
            rel_q <= rel_d;
            valid_q <= valid_d;
            mode_q <= mode_d;
            status_q <= status_d;
            res_asrt_q <= res_asrt_d;
            res_rel_q <= res_rel_d;
            res_wid_q <= res_wid_d;
        end
    end
    assign result_valid = valid_q;
    assign result_mode = mode_q;
    assign result_status = status_q;
    assign result_assert = res_asrt_q;
    assign result_release = res_rel_q;
    assign result_width = res_wid_q;
endmodule

// File: tb/tb_delay_timer_monitor.sv
// tb_delay_timer_monitor: directed vectors, randomized trigger cycles and reset/overflow sequences
module tb_delay_timer_monitor;
    localparam int IMM_TOL = 2;
    typedef struct {
        int mode;
        int status;
        int a;
        int r;
        int w;
    } rec_t;
    typedef struct {
        string name;
        int tf;
        int ta;
        int tr;
        rec_t exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger_in = 1'b0;
    logic delay_out_n = 1'b1;
    logic result_valid;
    logic [1:0] result_mode, result_status;
    logic [7:0] result_assert, result_release, result_width;
    int tests = 0;
    int fails = 0;
    rec_t q[$];
    vec_t vecs[9];

    delay_timer_monitor #(.WEIGHT_BIT_WIDTH(8), .IMM_TOL(IMM_TOL)) dut (
        .clk(clk), .rst(rst), .trigger_in(trigger_in), .delay_out_n(delay_out_n),
        .result_valid(result_valid), .result_mode(result_mode), .result_status(result_status),
        .result_assert(result_assert), .result_release(result_release), .result_width(result_width)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && result_valid)
            q.push_back(rec_t'{int'(result_mode), int'(result_status), int'(result_assert),
                               int'(result_release), int'(result_width)});

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(int n, logic t, logic o);
        trigger_in = t;
        delay_out_n = o;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // times relative to the trigger rise; negative means the edge never happens
    task automatic play(int tf, int ta, int tr);
        int last;
        last = tf > ta ? tf : ta;
        last = last > tr ? last : tr;
        for (int c = 0; c <= last; c++)
            drive(1, c < tf, !(ta >= 0 && c >= ta && (tr < 0 || c < tr)));
        drive(8, 1'b0, 1'b1);
    endtask

    function automatic rec_t model(int tf, int ta, int tr);
        rec_t e;
        int a_dly, r_dly;
        e = '{0, 0, 0, 0, 0};
        if (ta < 0 || ta > tf) begin
            e.mode = 1;
            e.status = 1;
            e.a = tf;
        end else if (tr < tf) begin
            e.a = ta;
            e.w = tr - ta;
        end else begin
            e.a = ta;
            e.r = tr - tf;
            e.w = tr - ta;
            a_dly = int'(e.a > IMM_TOL);
            r_dly = int'(e.r > IMM_TOL);
            e.mode = (a_dly + r_dly > 0) ? r_dly * 2 + a_dly : 1;
        end
        return e;
    endfunction

    // negative expected fields are not compared
    task automatic check_rec(string name, rec_t e);
        rec_t g;
        if (q.size() == 0) chk({name, ".present"}, 0, 1);
        else begin
            g = q.pop_front();
            if (e.mode >= 0) chk({name, ".mode"}, g.mode, e.mode);
            chk({name, ".status"}, g.status, e.status);
            chk({name, ".assert"}, g.a, e.a);
            if (e.r >= 0) chk({name, ".release"}, g.r, e.r);
            if (e.w >= 0) chk({name, ".width"}, g.w, e.w);
        end
    endtask

    task automatic check_outputs_zero(string name);
        chk({name, ".valid"}, int'(result_valid), 0);
        chk({name, ".mode"}, int'(result_mode), 0);
        chk({name, ".status"}, int'(result_status), 0);
        chk({name, ".assert"}, int'(result_assert), 0);
        chk({name, ".release"}, int'(result_release), 0);
        chk({name, ".width"}, int'(result_width), 0);
    endtask

    initial begin
        vecs[0] = '{"one_shot", 40, 1, 21, '{0, 0, 1, 0, 20}};
        vecs[1] = '{"dly_operate", 30, 10, 31, '{1, 0, 10, 1, 21}};
        vecs[2] = '{"dly_release", 15, 1, 55, '{2, 0, 1, 40, 54}};
        vecs[3] = '{"dly_dual", 50, 12, 62, '{3, 0, 12, 12, 50}};
        vecs[4] = '{"abort_no_assert", 5, -1, -1, '{1, 1, 5, 0, 0}};
        vecs[5] = '{"fall_release_same", 20, 3, 20, '{1, 0, 3, 0, 17}};
        vecs[6] = '{"assert_with_rise", 10, 0, 13, '{2, 0, 0, 3, 13}};
        vecs[7] = '{"tol_edge_zero_dly", 10, 2, 12, '{1, 0, 2, 2, 10}};
        vecs[8] = '{"tol_edge_plus_one", 10, 3, 13, '{3, 0, 3, 3, 10}};

        drive(3, 1'b0, 1'b1);
        check_outputs_zero("reset");
        rst = 1'b0;
        drive(4, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            play(vecs[i].tf, vecs[i].ta, vecs[i].tr);
            chk({vecs[i].name, ".count"}, q.size(), 1);
            check_rec(vecs[i].name, vecs[i].exp);
            q.delete();
        end

        for (int i = 0; i < 40; i++) begin
            int k, ta, tf, tr;
            k = int'($urandom_range(2, 0));
            if (k == 0) begin
                tf = 1 + int'($urandom_range(19, 0));
                ta = -1;
                tr = -1;
            end else if (k == 1) begin
                ta = int'($urandom_range(10, 0));
                tr = ta + 1 + int'($urandom_range(29, 0));
                tf = tr + 1 + int'($urandom_range(9, 0));
            end else begin
                ta = int'($urandom_range(10, 0));
                tf = ta + 1 + int'($urandom_range(29, 0));
                tr = tf + int'($urandom_range(10, 0));
            end
            play(tf, ta, tr);
            chk($sformatf("rand%0d.count", i), q.size(), 1);
            check_rec($sformatf("rand%0d(tf=%0d,ta=%0d,tr=%0d)", i, tf, ta, tr), model(tf, ta, tr));
            q.delete();
        end

        drive(1, 1'b1, 1'b1);
        drive(9, 1'b1, 1'b0);
        drive(10, 1'b0, 1'b0);
        drive(5, 1'b1, 1'b0);
        drive(5, 1'b1, 1'b1);
        drive(10, 1'b1, 1'b0);
        drive(5, 1'b0, 1'b0);
        drive(10, 1'b0, 1'b1);
        chk("retrigger.count", q.size(), 2);
        check_rec("retrigger.abort", '{-1, 1, 1, 10, 19});
        check_rec("retrigger.next", '{3, 0, 10, 5, 15});
        q.delete();

        play(400, 1, 301);
        chk("overflow.count", q.size(), 1);
        check_rec("overflow", '{-1, 2, 1, 0, 255});
        q.delete();

        drive(5, 1'b1, 1'b1);
        rst = 1'b1;
        drive(4, 1'b0, 1'b1);
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        drive(10, 1'b0, 1'b1);
        chk("mid_reset.no_record", q.size(), 0);
        q.delete();
        play(40, 1, 21);
        chk("after_reset.count", q.size(), 1);
        check_rec("after_reset", '{0, 0, 1, 0, 20});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
